// File: rtl/serial_adder_subtractor_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the add_n operation encodings.
package serial_adder_subtractor_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_adder_subtractor_full_adder.sv
// Single-bit full adder used as the one arithmetic slice of the serial datapath.
module serial_adder_subtractor_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Plain combinational full-adder equations.
   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (cin & (a ^ b));
   end

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial n-bit two's-complement adder/subtractor. One full-adder slice is
// reused for n cycles, consuming operands LSB-first; subtraction is done as
// x + ~y + 1 by inverting y on capture and seeding the carry with add_n.
module serial_adder_subtractor
   import serial_adder_subtractor_pkg::*;
#(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   input  logic         add_n,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] s,
   output logic         c_out,
   output logic         overflow
);

   localparam int CNT_W = $clog2(n);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(n - 1);

   state_t           state_q;
   state_t           state_d;
   logic [n-1:0]     op_a_q;
   logic [n-1:0]     op_b_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic [n-1:0]     s_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             fa_sum;
   logic             fa_cy;

   serial_adder_subtractor_full_adder u_fa (
      .a    (op_a_q[0]),
      .b    (op_b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cy)
   );

   // Next-state logic: start only matters in IDLE; SHIFT leaves after the MSB slice.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == CNT_LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Operand shift registers: pure data, only meaningful after a capture.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && start) begin
         op_a_q <= x;
         op_b_q <= y ^ {n{add_n}};
      end else if (state_q == S_SHIFT) begin
         op_a_q <= op_a_q >> 1;
         op_b_q <= op_b_q >> 1;
      end
   end

   // Counter, carry FF, result shift register and flags. On the last slice
   // carry_q still holds the carry into the MSB, so overflow is cin ^ cout.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  carry_q <= (add_n == SUB);
                  cnt_q   <= '0;
                  s_q     <= '0;
               end
            end
            S_SHIFT: begin
               s_q     <= {fa_sum, s_q[n-1:1]};
               carry_q <= fa_cy;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  c_out_q <= fa_cy;
                  ovf_q   <= fa_cy ^ carry_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign s        = s_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Self-checking bench for serial_adder_subtractor (n=4): directed vector table,
// hand-written corner sequences, and an exhaustive back-to-back sweep.
module tb_serial_adder_subtractor;
   import serial_adder_subtractor_pkg::*;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] x;
   logic [N-1:0] y;
   logic         add_n;
   logic         busy;
   logic         done;
   logic [N-1:0] s;
   logic         c_out;
   logic         overflow;

   int total = 0;
   int bad   = 0;

   serial_adder_subtractor #(.n(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .x        (x),
      .y        (y),
      .add_n    (add_n),
      .busy     (busy),
      .done     (done),
      .s        (s),
      .c_out    (c_out),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic         add_n;
      logic [N-1:0] s;
      logic         c;
      logic         ov;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a negedge: pulse start for one cycle, then wait for done.
   // Returns at the negedge where done is high; lat = negedges after the
   // acceptance edge's own negedge (expected n), or -1 on timeout.
   task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] ya,
                         input logic an, output int lat);
      x = xa; y = ya; add_n = an; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 3 * N; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   // Independent reference: integer add/sub, flags from range and 5-bit sum.
   function automatic logic [5:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic an);
      int sa, sb, r;
      logic [N:0] u;
      logic ov;
      sa = (a >= 8) ? int'(a) - 16 : int'(a);
      sb = (b >= 8) ? int'(b) - 16 : int'(b);
      r  = an ? sa - sb : sa + sb;
      ov = (r > 7) || (r < -8);
      u  = an ? ({1'b0, a} + {1'b0, ~b} + 5'd1) : ({1'b0, a} + {1'b0, b});
      return {u[N], ov, u[N-1:0]};
   endfunction

   vec_t vecs[10];
   int   lat;
   int   dones;
   bit   seen;
   logic [N-1:0] hold_s;
   logic [5:0]   exp;

   initial begin
      vecs[0] = '{4'd5,  4'd6, ADD, 4'd11, 1'b0, 1'b1};
      vecs[1] = '{4'd5,  4'd6, SUB, 4'd15, 1'b0, 1'b0};
      vecs[2] = '{4'd8,  4'd1, SUB, 4'd7,  1'b1, 1'b1};
      vecs[3] = '{4'd15, 4'd1, ADD, 4'd0,  1'b1, 1'b0};
      vecs[4] = '{4'd7,  4'd1, ADD, 4'd8,  1'b0, 1'b1};
      vecs[5] = '{4'd0,  4'd0, SUB, 4'd0,  1'b1, 1'b0};
      vecs[6] = '{4'd3,  4'd2, SUB, 4'd1,  1'b1, 1'b0};
      vecs[7] = '{4'd2,  4'd3, SUB, 4'd15, 1'b0, 1'b0};
      vecs[8] = '{4'd8,  4'd8, ADD, 4'd0,  1'b1, 1'b1};
      vecs[9] = '{4'd9,  4'd7, ADD, 4'd0,  1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; x = '0; y = '0; add_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_s", s, 0);
      check("reset_cout", c_out, 0);
      check("reset_ovf", overflow, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table; the first entry also checks latency and pulse width.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].x, vecs[i].y, vecs[i].add_n, lat);
         if (i == 0) check("latency", lat, N);
         else        check("timeout", (lat > 0), 1);
         check($sformatf("vec%0d_s", i), s, vecs[i].s);
         check($sformatf("vec%0d_cout", i), c_out, vecs[i].c);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ov);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), {busy, done}, 2'b00);
      end

      // Input churn and repeated start while busy: one done, captured operands used.
      x = 4'd5; y = 4'd6; add_n = SUB; start = 1'b1;
      dones = 0; seen = 0;
      for (int i = 1; i <= N + 4; i++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            seen = 1;
            start = 1'b0;
            check("churn_s", s, 4'd15);
            check("churn_flags", {c_out, overflow}, 2'b00);
         end else if (!seen) begin
            x = 4'($urandom); y = 4'($urandom); add_n = 1'($urandom); start = 1'b1;
         end
      end
      start = 1'b0;
      check("churn_dones", dones, 1);
      check("churn_idle", busy, 0);

      // Reset during the 2nd SHIFT cycle after an op that left overflow set.
      run_op(4'd5, 4'd6, ADD, lat);
      check("pre_reset_ovf", overflow, 1);
      @(negedge clk);
      x = 4'd15; y = 4'd1; add_n = ADD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_s", s, 0);
      check("abort_flags", {c_out, overflow}, 2'b00);
      dones = 0;
      for (int i = 0; i < 2 * N; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_op(4'd7, 4'd1, ADD, lat);
      check("post_abort_timeout", (lat > 0), 1);
      check("post_abort_s", s, 4'd8);
      check("post_abort_flags", {c_out, overflow}, 2'b01);
      @(negedge clk);

      // Exhaustive back-to-back sweep.
      for (int a = 0; a < 2; a++) begin
         for (int xx = 0; xx < 16; xx++) begin
            for (int yy = 0; yy < 16; yy++) begin
               run_op(4'(xx), 4'(yy), 1'(a), lat);
               exp = ref_model(4'(xx), 4'(yy), 1'(a));
               if (lat < 0) begin
                  check($sformatf("sweep_timeout_%0d_%0d_%0d", xx, yy, a), 0, 1);
               end else begin
                  check($sformatf("sweep_%0d_%0d_%0d", xx, yy, a),
                        {c_out, overflow, s}, exp);
               end
               hold_s = s;
               @(negedge clk);
               check($sformatf("sweep_hold_%0d_%0d_%0d", xx, yy, a), {busy, s}, {1'b0, hold_s});
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
